// File: rtl/count_monitor.sv
// count_monitor: classifies a same-clock counter's transitions (step/hold/jump/wrap)
// and keeps a saturating wrap tally, sticky flags and a compare match.
module count_monitor #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count,
    input  logic [WIDTH-1:0]  cmp_value,
    input  logic              cmp_en,
    input  logic              clr,
    output logic              step,
    output logic              hold,
    output logic              jump,
    output logic              wrap,
    output logic              match,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              wrap_sat,
    output logic              jump_seen
);
    typedef enum logic {PRIME, TRACK} state_t;
    state_t state_q;
    logic [WIDTH-1:0] prev_q, prev_inc;
    logic trk, is_hold, is_step, is_jump, is_wrap;
    logic step_q, hold_q, jump_q, wrap_q, match_q;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic wrap_sat_q, wrap_sat_d, jump_seen_q, jump_seen_d;
    always_comb begin
        prev_inc    = prev_q + WIDTH'(1);
        trk         = state_q == TRACK;
        is_hold     = trk && count == prev_q;
        is_step     = trk && count == prev_inc;
        is_jump     = trk && !is_hold && !is_step;
        is_wrap     = is_step && prev_q == '1;
        // clr wins over a coincident event, so that event never reaches the tally
        wrap_cnt_d  = clr ? '0 : (is_wrap && wrap_cnt_q != '1) ? wrap_cnt_q + WRAP_W'(1) : wrap_cnt_q;
        wrap_sat_d  = !clr && (wrap_sat_q || (is_wrap && wrap_cnt_q == '1));
        jump_seen_d = !clr && (jump_seen_q || is_jump);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRIME;
            prev_q      <= '0;
            step_q      <= 1'b0;
            hold_q      <= 1'b0;
            jump_q      <= 1'b0;
            wrap_q      <= 1'b0;
            match_q     <= 1'b0;
            wrap_cnt_q  <= '0;
            wrap_sat_q  <= 1'b0;
            jump_seen_q <= 1'b0;
        end else begin
            state_q     <= TRACK;
            prev_q      <= count;
            step_q      <= is_step;
            hold_q      <= is_hold;
            jump_q      <= is_jump;
            wrap_q      <= is_wrap;
            match_q     <= cmp_en && count == cmp_value;
            wrap_cnt_q  <= wrap_cnt_d;
            wrap_sat_q  <= wrap_sat_d;
            jump_seen_q <= jump_seen_d;
        end
    end
    assign step      = step_q;
    assign hold      = hold_q;
    assign jump      = jump_q;
    assign wrap      = wrap_q;
    assign match     = match_q;
    assign wrap_cnt  = wrap_cnt_q;
    assign wrap_sat  = wrap_sat_q;
    assign jump_seen = jump_seen_q;
endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: table-driven scoreboard bench for count_monitor (WRAP_W=2 to reach saturation).
module tb_count_monitor;
    localparam logic [4:0] Z = 5'b00000, S = 5'b10000, H = 5'b01000, J = 5'b00100;
    localparam logic [4:0] SW = 5'b10010, SM = 5'b10001, HM = 5'b01001;
    typedef struct {
        logic       rst, clr, en;
        logic [3:0] cv, cnt;
        logic [4:0] p;
        logic [1:0] wc;
        logic       sat, js;
    } vec_t;
    typedef struct {
        logic [8:0] exp;
        string      name;
    } sb_t;
    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, cmp_en = 1'b0;
    logic [3:0] count = 4'd0, cmp_value = 4'd0;
    logic step, hold, jump, wrap, match, wrap_sat, jump_seen;
    logic [1:0] wrap_cnt;
    int checks = 0, errors = 0;
    sb_t sbq[$];
    vec_t tbl[25];
    count_monitor #(.WIDTH(4), .WRAP_W(2)) dut (
        .clk(clk), .rst(rst), .count(count), .cmp_value(cmp_value), .cmp_en(cmp_en), .clr(clr),
        .step(step), .hold(hold), .jump(jump), .wrap(wrap), .match(match),
        .wrap_cnt(wrap_cnt), .wrap_sat(wrap_sat), .jump_seen(jump_seen)
    );
    always #5 clk = ~clk;
    task automatic apply(input vec_t v, input string name);
        sb_t e, g;
        logic [8:0] act;
        rst = v.rst;
        clr = v.clr;
        cmp_en = v.en;
        cmp_value = v.cv;
        count = v.cnt;
        e.exp = {v.p, v.wc, v.sat, v.js};
        e.name = name;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        act = {step, hold, jump, wrap, match, wrap_cnt, wrap_sat, jump_seen};
        g = sbq.pop_front();
        checks++;
        if (act !== g.exp) begin
            errors++;
            $display("FAIL %s: got {s,h,j,w,m,cnt,sat,js}=%b required %b", g.name, act, g.exp);
        end
    endtask
    initial begin
        tbl = '{
            '{1,0,0,0,0,  Z,0,0,0}, '{1,0,0,0,0,  Z,0,0,0}, '{0,0,0,0,0,  Z,0,0,0}, '{0,0,0,0,0,  H,0,0,0},
            '{1,0,0,0,5,  Z,0,0,0}, '{0,0,0,0,5,  Z,0,0,0}, '{0,0,0,0,6,  S,0,0,0}, '{0,0,0,0,7,  S,0,0,0},
            '{0,0,0,0,8,  S,0,0,0}, '{0,0,0,0,9,  S,0,0,0}, '{0,0,0,0,9,  H,0,0,0}, '{0,0,0,0,9,  H,0,0,0},
            '{0,0,0,0,12, J,0,0,1}, '{0,0,1,14,13,S,0,0,1}, '{0,0,1,14,14,SM,0,0,1},'{0,0,1,14,15,S,0,0,1},
            '{0,0,1,14,0, SW,1,0,1},'{0,0,1,14,1, S,1,0,1}, '{0,1,0,0,1,  H,0,0,0}, '{0,0,0,0,14, J,0,0,1},
            '{1,0,0,0,15, Z,0,0,0}, '{0,0,0,0,0,  Z,0,0,0}, '{0,0,0,0,1,  S,0,0,0}, '{0,0,0,1,1,  H,0,0,0},
            '{0,0,1,1,1,  HM,0,0,0}
        };
        for (int i = 0; i < 25; i++) apply(tbl[i], $sformatf("vec%0d", i));
        apply('{1,0,0,0,15, Z,0,0,0}, "sat_rst");
        apply('{0,0,0,0,15, Z,0,0,0}, "sat_prime");
        for (int i = 1; i <= 4; i++) begin
            apply('{0,0,0,0,0, SW, (i < 3) ? 2'(i) : 2'd3, i == 4, i > 1}, $sformatf("sat_wrap%0d", i));
            if (i < 4) apply('{0,0,0,0,15, J, (i < 3) ? 2'(i) : 2'd3, 1'b0, 1'b1}, $sformatf("sat_reload%0d", i));
        end
        apply('{0,0,0,0,15, J,3,1,1}, "sat_hold");
        apply('{0,1,0,0,0,  SW,0,0,0}, "clr_on_wrap");
        apply('{0,0,0,0,1,  S,0,0,0}, "after_clr");
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_monitor.md
# count_monitor

Observer stage placed directly downstream of the 4-bit loadable counter; it samples the counter's `count` output on the same clock. Each cycle it classifies the counter's behaviour as step, hold or jump, and detects wrap-around (max to 0). It also keeps a saturating wrap tally and flags a programmable compare match. It is passive: it never drives the counter, and its outputs feed status/interrupt logic.

## Interface
- `WIDTH`, 4, width of the monitored count.
- `WRAP_W`, 8, width of the wrap tally.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `count`  in  WIDTH  counter output being monitored.
- `cmp_value`  in  WIDTH  compare value for `match`.
- `cmp_en`  in  1  enables match detection.
- `clr`  in  1  synchronous clear of `wrap_cnt`, `wrap_sat` and `jump_seen`.
- `step`  out  1  pulse: count advanced by +1 (mod 2^WIDTH).
- `hold`  out  1  pulse: count unchanged.
- `jump`  out  1  pulse: any other change (treated as a load).
- `wrap`  out  1  pulse: transition from 2^WIDTH-1 to 0.
- `match`  out  1  pulse: sampled count == `cmp_value` with `cmp_en`=1.
- `wrap_cnt`  out  WRAP_W  number of wraps since reset/clr, saturating.
- `wrap_sat`  out  1  sticky: a wrap occurred while `wrap_cnt` was at max.
- `jump_seen`  out  1  sticky: at least one jump since reset/clr.

## Operation
- Internal registers: `prev` (WIDTH) and a 2-state FSM {PRIME, TRACK}.
- PRIME: on the edge, `prev` <= `count`, move to TRACK. `step`/`hold`/`jump`/`wrap` stay 0. `match` is still evaluated.
- TRACK: on each edge, compare `count` against `prev`, then `prev` <= `count`.
  - `count == prev` -> `hold`=1.
  - `count == prev+1` (mod 2^WIDTH) -> `step`=1. If additionally `prev` = 2^WIDTH-1, then `wrap`=1.
  - Otherwise -> `jump`=1 and `jump_seen` <= 1.
- Exactly one of `step`/`hold`/`jump` is 1 in every TRACK output cycle.
- A load whose value equals prev+1 is classified as step; a load of the same value is classified as hold. Both are indistinguishable by design. A load of 0 from 2^WIDTH-1 is a step plus wrap.
- Wrap tally: on `wrap`, `wrap_cnt` increments. At 2^WRAP_W-1 it holds and `wrap_sat` <= 1.
- Priority: `rst` > `clr` > event update. With `clr`=1, `wrap_cnt`=0, `wrap_sat`=0 and `jump_seen`=0 after the edge; a coincident wrap or jump is dropped from the tally/stickies. `clr` does not affect the FSM, `prev` or the pulse outputs.
- `match` <= `cmp_en` && (`count` == `cmp_value`), evaluated in both states.

## Timing
- All outputs are registered. Reset values: all pulses 0, `wrap_cnt`=0, `wrap_sat`=0, `jump_seen`=0, `prev`=0, FSM=PRIME.
- Latency: a transition between the samples at edges k-1 and k is reported on outputs after edge k. Pulses last exactly one cycle per event.
- First classification occurs on the second edge after `rst` deasserts.
- `rst` asserted mid-operation: on that edge all state returns to the reset values and the FSM goes to PRIME. There is no classification across a reset.
- `count` is assumed to change only just after `clk` edges, because it comes from the same-clock counter. No synchronisers are provided.

## Test plan
- Reset then prime: hold `rst`=1 for 2 edges, release with `count`=0 -> all outputs 0. On the next edge, `hold`=1 only if `count` stays 0.
- Load and count: `count` sequence 5,6,7,8,9 -> `step`=1 on 4 consecutive cycles; `jump`=0 and `jump_seen`=0 throughout.
- Hold and jump: sequence 9,9,9,12 -> `hold`=1 for two cycles, then `jump`=1 and `jump_seen` latches 1.
- Wrap: sequence 12,13,14,15,0,1 -> `wrap`=1 exactly once (for 15->0) and `wrap_cnt`=1. With `cmp_value`=14 and `cmp_en`=1, `match` pulses once, one cycle after 14 is sampled.
- Saturation: with `WRAP_W`=2, drive 4 wraps -> `wrap_cnt` reaches 3 and stays at 3, and `wrap_sat`=1 after the 4th wrap. Then assert `clr` on a wrap cycle -> `wrap_cnt`=0 and `wrap_sat`=0.
- Mid-run reset: assert `rst` during 14->15 counting -> after the edge all outputs are 0 and FSM=PRIME. The next classification comes two edges after release.
